// File: rtl/decode_issue_if.sv
// Decode/issue bus: decode-stage instruction and control, execute-stage
// handshake, writeback releases and the registered DE outputs.
interface decode_issue_if #(
    parameter int N = 32,
    parameter int R = 5
);
    logic [N-1:0] InstrD;
    logic         ValidD;
    logic         RegWriteD;
    logic         RegWriteVD;
    logic [1:0]   RegSrcD;
    logic         ReadyD;
    logic         HazardD;
    logic         StallE;
    logic         FlushE;
    logic         RegWriteW;
    logic         RegWriteVW;
    logic [R-1:0] WA3W;
    logic         ValidE;
    logic [R-1:0] RA1E;
    logic [R-1:0] RA2E;
    logic [R-1:0] WA3E;
    logic         RegWriteE;
    logic         RegWriteVE;
    logic         SbErr;

    modport master (
        output InstrD, ValidD, RegWriteD, RegWriteVD, RegSrcD,
        output StallE, FlushE, RegWriteW, RegWriteVW, WA3W,
        input  ReadyD, HazardD, ValidE, RA1E, RA2E, WA3E,
        input  RegWriteE, RegWriteVE, SbErr
    );

    modport slave (
        input  InstrD, ValidD, RegWriteD, RegWriteVD, RegSrcD,
        input  StallE, FlushE, RegWriteW, RegWriteVW, WA3W,
        output ReadyD, HazardD, ValidE, RA1E, RA2E, WA3E,
        output RegWriteE, RegWriteVE, SbErr
    );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage with scalar and vector pending-write scoreboards.
// Optional SB_WB_BYPASS_EN: hazard checks see the same-cycle writeback release.
module decode_issue #(
    parameter int N  = 32,
    parameter int R  = 5,
    parameter int CW = 2
) (
    input logic           clk,
    input logic           rst,
    decode_issue_if.slave di
);
    localparam int            DEPTH    = 2 ** R;
    localparam logic [R-1:0]  PC_REG   = R'(32'd15);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
`ifdef SB_WB_BYPASS_EN
    localparam logic WB_BYPASS = 1'b1;
`else
    localparam logic WB_BYPASS = 1'b0;
`endif

    // Count as seen by the hazard checks.
    function automatic logic [CW-1:0] chk_cnt(input logic [CW-1:0] c, input logic dec);
        return (WB_BYPASS && dec && (c != CNT_ZERO)) ? (c - CNT_ONE) : c;
    endfunction

    function automatic logic [CW-1:0] next_cnt(input logic [CW-1:0] c, input logic inc,
                                               input logic dec);
        logic [CW-1:0] r;
        case ({inc, dec})
            2'b10:   r = (c == CNT_MAX) ? c : (c + CNT_ONE);
            2'b01:   r = (c == CNT_ZERO) ? c : (c - CNT_ONE);
            default: r = c;
        endcase
        return r;
    endfunction

    logic [CW-1:0] scnt_q [DEPTH];
    logic [CW-1:0] scnt_d [DEPTH];
    logic [CW-1:0] vcnt_q [DEPTH];
    logic [CW-1:0] vcnt_d [DEPTH];
    logic          sb_err_q, sb_err_d;
    logic          valid_q, valid_d;
    logic [R-1:0]  ra1_q, ra1_d, ra2_q, ra2_d, wa3_q, wa3_d;
    logic          we_q, we_d, wev_q, wev_d;

    logic          v_s, swb_s, vwb_s, src_pend_s, sat_s, hazard_s, issue_s;
    logic [R-1:0]  rd_s, rs_s, rt_s, ra1_s, ra2_s;
    logic          unused_s;

    assign v_s   = di.InstrD[31];
    assign rd_s  = R'(di.InstrD[25:21]);
    assign rs_s  = R'(di.InstrD[20:16]);
    assign rt_s  = R'(di.InstrD[15:11]);
    assign ra1_s = di.RegSrcD[1] ? PC_REG : rs_s;
    assign ra2_s = di.RegSrcD[0] ? rd_s : rt_s;
    assign unused_s = ^{di.InstrD[30:26], di.InstrD[10:0]};

    // Scalar writebacks to $pc carry no scoreboard state.
    assign swb_s = di.RegWriteW && (di.WA3W != PC_REG);
    assign vwb_s = di.RegWriteVW;

    assign src_pend_s = v_s ?
        ((chk_cnt(vcnt_q[ra1_s], vwb_s && (di.WA3W == ra1_s)) != CNT_ZERO) ||
         (chk_cnt(vcnt_q[ra2_s], vwb_s && (di.WA3W == ra2_s)) != CNT_ZERO)) :
        (((ra1_s != PC_REG) &&
          (chk_cnt(scnt_q[ra1_s], swb_s && (di.WA3W == ra1_s)) != CNT_ZERO)) ||
         ((ra2_s != PC_REG) &&
          (chk_cnt(scnt_q[ra2_s], swb_s && (di.WA3W == ra2_s)) != CNT_ZERO)));

    assign sat_s =
        (di.RegWriteD && (rd_s != PC_REG) &&
         (chk_cnt(scnt_q[rd_s], swb_s && (di.WA3W == rd_s)) == CNT_MAX)) ||
        (di.RegWriteVD &&
         (chk_cnt(vcnt_q[rd_s], vwb_s && (di.WA3W == rd_s)) == CNT_MAX));

    assign hazard_s   = di.ValidD && (src_pend_s || sat_s);
    assign issue_s    = di.ValidD && !hazard_s && !di.StallE && !di.FlushE;
    assign di.HazardD = hazard_s;
    assign di.ReadyD  = di.FlushE || (!di.StallE && !hazard_s);

    // Scoreboard next state: issue increments, writeback decrements, zero-decrement flags error.
    always_comb begin
        scnt_d   = scnt_q;
        vcnt_d   = vcnt_q;
        sb_err_d = sb_err_q;
        for (int i = 0; i < DEPTH; i++) begin
            scnt_d[i] = next_cnt(scnt_q[i],
                                 issue_s && di.RegWriteD && (rd_s == R'(i)) && (R'(i) != PC_REG),
                                 swb_s && (di.WA3W == R'(i)));
            vcnt_d[i] = next_cnt(vcnt_q[i],
                                 issue_s && di.RegWriteVD && (rd_s == R'(i)),
                                 vwb_s && (di.WA3W == R'(i)));
            sb_err_d = sb_err_d ||
                (swb_s && (di.WA3W == R'(i)) && (scnt_q[i] == CNT_ZERO) &&
                 !(issue_s && di.RegWriteD && (rd_s == R'(i)))) ||
                (vwb_s && (di.WA3W == R'(i)) && (vcnt_q[i] == CNT_ZERO) &&
                 !(issue_s && di.RegWriteVD && (rd_s == R'(i))));
        end
    end

    // DE register next state; flush beats stall.
    always_comb begin
        valid_d = valid_q;
        ra1_d   = ra1_q;
        ra2_d   = ra2_q;
        wa3_d   = wa3_q;
        we_d    = we_q;
        wev_d   = wev_q;
        if (di.FlushE) begin
            valid_d = 1'b0;
        end else if (di.StallE) begin
            valid_d = valid_q;
        end else if (issue_s) begin
            valid_d = 1'b1;
            ra1_d   = ra1_s;
            ra2_d   = ra2_s;
            wa3_d   = rd_s;
            we_d    = di.RegWriteD;
            wev_d   = di.RegWriteVD;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                scnt_q[i] <= CNT_ZERO;
                vcnt_q[i] <= CNT_ZERO;
            end
            sb_err_q <= 1'b0;
            valid_q  <= 1'b0;
            ra1_q    <= {R{1'b0}};
            ra2_q    <= {R{1'b0}};
            wa3_q    <= {R{1'b0}};
            we_q     <= 1'b0;
            wev_q    <= 1'b0;
        end else begin
            scnt_q   <= scnt_d;
            vcnt_q   <= vcnt_d;
            sb_err_q <= sb_err_d;
            valid_q  <= valid_d;
            ra1_q    <= ra1_d;
            ra2_q    <= ra2_d;
            wa3_q    <= wa3_d;
            we_q     <= we_d;
            wev_q    <= wev_d;
        end
    end

    assign di.ValidE     = valid_q;
    assign di.RA1E       = ra1_q;
    assign di.RA2E       = ra2_q;
    assign di.WA3E       = wa3_q;
    assign di.RegWriteE  = we_q;
    assign di.RegWriteVE = wev_q;
    assign di.SbErr      = sb_err_q;
endmodule

// File: tb/tb_decode_issue.sv
// Scoreboarded bench for decode_issue: RAW/WAW-saturation stalls, $pc, flush/stall,
// vector/scalar independence and reset; expectations follow SB_WB_BYPASS_EN.
module tb_decode_issue;
    typedef struct packed {
        logic [4:0] ra1;
        logic [4:0] ra2;
        logic [4:0] wa3;
        logic       we;
        logic       wev;
    } de_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    decode_issue_if #(.N(32), .R(5)) bus ();
    decode_issue #(.N(32), .R(5), .CW(2)) dut (.clk(clk), .rst(rst), .di(bus));

    de_t  exp_q[$];
    de_t  model_de;
    logic model_v;
    logic exp_sberr;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] b_instr;
    logic        b_valid, b_rw, b_rwv, b_stall, b_flush, b_wb, b_wbv;
    logic [1:0]  b_src;
    logic [4:0]  b_wa;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic v, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {v, 5'b00000, rd, rs, rt, 11'b0};
    endfunction

    task automatic idle();
        b_instr = 32'h0; b_valid = 1'b0; b_rw = 1'b0; b_rwv = 1'b0; b_src = 2'b00;
        b_stall = 1'b0; b_flush = 1'b0; b_wb = 1'b0; b_wbv = 1'b0; b_wa = 5'd0;
    endtask

    task automatic ins(input logic v, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic rw, input logic rwv,
                       input logic [1:0] src);
        idle();
        b_instr = mk(v, rd, rs, rt);
        b_valid = 1'b1; b_rw = rw; b_rwv = rwv; b_src = src;
    endtask

    task automatic apply();
        bus.InstrD = b_instr; bus.ValidD = b_valid; bus.RegWriteD = b_rw;
        bus.RegWriteVD = b_rwv; bus.RegSrcD = b_src; bus.StallE = b_stall;
        bus.FlushE = b_flush; bus.RegWriteW = b_wb; bus.RegWriteVW = b_wbv; bus.WA3W = b_wa;
    endtask

    function automatic de_t cur_de();
        return {bus.RA1E, bus.RA2E, bus.WA3E, bus.RegWriteE, bus.RegWriteVE};
    endfunction

    // One clock: drive, check combinational handshake, then registered outputs.
    task automatic cyc(input string tag, input logic exp_haz);
        logic issued;
        de_t  e;
        @(negedge clk);
        apply();
        #1;
        check_eq({tag, ".haz"}, {31'b0, bus.HazardD}, {31'b0, exp_haz});
        check_eq({tag, ".rdy"}, {31'b0, bus.ReadyD}, {31'b0, b_flush | (~b_stall & ~exp_haz)});
        issued = b_valid & ~exp_haz & ~b_stall & ~b_flush;
        e.ra1 = b_src[1] ? 5'd15 : b_instr[20:16];
        e.ra2 = b_src[0] ? b_instr[25:21] : b_instr[15:11];
        e.wa3 = b_instr[25:21];
        e.we  = b_rw;
        e.wev = b_rwv;
        if (issued) exp_q.push_back(e);
        if (b_flush) model_v = 1'b0;
        else if (!b_stall) model_v = issued;
        @(posedge clk);
        #1;
        check_eq({tag, ".vld"}, {31'b0, bus.ValidE}, {31'b0, model_v});
        if (issued && exp_q.size() != 0) begin
            model_de = exp_q.pop_front();
            check_eq({tag, ".de"}, {15'b0, cur_de()}, {15'b0, model_de});
        end else if (b_stall && !b_flush && model_v) begin
            check_eq({tag, ".hold"}, {15'b0, cur_de()}, {15'b0, model_de});
        end
        check_eq({tag, ".err"}, {31'b0, bus.SbErr}, {31'b0, exp_sberr});
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        idle();
        apply();
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        model_v = 1'b0; model_de = '0; exp_sberr = 1'b0;
        check_eq({tag, ".vld"}, {31'b0, bus.ValidE}, 32'h0);
        check_eq({tag, ".de"}, {15'b0, cur_de()}, 32'h0);
        check_eq({tag, ".err"}, {31'b0, bus.SbErr}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        idle();
        apply();
        do_reset("rst0");

        // RAW on scalar r3
        ins(1'b0, 5'd3, 5'd1, 5'd2, 1'b1, 1'b0, 2'b00); cyc("s1.iss", 1'b0);
        ins(1'b0, 5'd4, 5'd3, 5'd2, 1'b1, 1'b0, 2'b00); cyc("s1.raw0", 1'b1);
        cyc("s1.raw1", 1'b1);
        b_wb = 1'b1; b_wa = 5'd3;
`ifdef SB_WB_BYPASS_EN
        cyc("s1.wb", 1'b0);
`else
        cyc("s1.wb", 1'b1);
        b_wb = 1'b0; cyc("s1.rel", 1'b0);
`endif
        idle(); b_wb = 1'b1; b_wa = 5'd4; cyc("s1.wb4", 1'b0);

        // Saturate r7 at 3 pending writes
        for (int i = 0; i < 3; i++) begin
            ins(1'b0, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 2'b00); cyc("s2.iss", 1'b0);
        end
        cyc("s2.sat", 1'b1);
        b_wb = 1'b1; b_wa = 5'd7;
`ifdef SB_WB_BYPASS_EN
        cyc("s2.wb", 1'b0);
`else
        cyc("s2.wb", 1'b1);
        b_wb = 1'b0; cyc("s2.rel", 1'b0);
`endif
        for (int i = 0; i < 3; i++) begin
            idle(); b_wb = 1'b1; b_wa = 5'd7; cyc("s2.drain", 1'b0);
        end

        // $pc writes never pend
        for (int i = 0; i < 4; i++) begin
            ins(1'b0, 5'd15, 5'd9, 5'd2, 1'b1, 1'b0, 2'b10); cyc("s3.pc", 1'b0);
        end
        ins(1'b0, 5'd1, 5'd3, 5'd15, 1'b0, 1'b0, 2'b00); cyc("s3.rd15", 1'b0);

        // Stall hold, then stall+flush drops the decode instruction
        ins(1'b0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b0, 2'b00); cyc("s4.iss", 1'b0);
        ins(1'b0, 5'd6, 5'd1, 5'd2, 1'b1, 1'b0, 2'b00); b_stall = 1'b1; cyc("s4.stall", 1'b0);
        b_flush = 1'b1; cyc("s4.flush", 1'b0);
        ins(1'b0, 5'd1, 5'd6, 5'd2, 1'b0, 1'b0, 2'b00); cyc("s4.r6", 1'b0);
        ins(1'b0, 5'd1, 5'd5, 5'd2, 1'b0, 1'b0, 2'b00); cyc("s4.r5", 1'b1);
        idle(); b_wb = 1'b1; b_wa = 5'd5; cyc("s4.wb5", 1'b0);

        // Scalar and vector tables are independent
        ins(1'b0, 5'd4, 5'd1, 5'd2, 1'b1, 1'b0, 2'b00); cyc("s5.s4", 1'b0);
        ins(1'b1, 5'd8, 5'd4, 5'd2, 1'b0, 1'b1, 2'b00); cyc("s5.vrd", 1'b0);
        ins(1'b1, 5'd4, 5'd1, 5'd2, 1'b0, 1'b1, 2'b00); cyc("s5.v4", 1'b0);
        ins(1'b1, 5'd9, 5'd4, 5'd2, 1'b0, 1'b0, 2'b00); cyc("s5.vraw", 1'b1);
        ins(1'b0, 5'd9, 5'd8, 5'd2, 1'b0, 1'b0, 2'b00); cyc("s5.srd8", 1'b0);

        // Reset with pending state, then an orphan writeback
        do_reset("rst1");
        idle(); b_wb = 1'b1; b_wa = 5'd2; exp_sberr = 1'b1; cyc("s6.wb", 1'b0);
        ins(1'b1, 5'd9, 5'd4, 5'd8, 1'b0, 1'b0, 2'b00); cyc("s6.v", 1'b0);
        ins(1'b0, 5'd9, 5'd4, 5'd2, 1'b0, 1'b0, 2'b00); cyc("s6.s", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 The block SHALL have parameter N, default 32, meaning instruction width.
REQ-002 The block SHALL have parameter R, default 5, meaning register address width; both tables hold 2**R entries.
REQ-003 The block SHALL have parameter CW, default 2, meaning per-register pending-write counter width.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 The block SHALL have these ports, clock and reset first:
  clk  in  1  clock
  rst  in  1  synchronous active-low reset
  InstrD  in  N  instruction in decode
  ValidD  in  1  InstrD valid
  RegWriteD  in  1  CU: scalar rd write
  RegWriteVD  in  1  CU: vector rd write
  RegSrcD  in  2  CU: [1] RA1=$pc(15), [0] RA2=rd
  ReadyD  out  1  decode accepts InstrD this cycle
  HazardD  out  1  RAW/WAW-saturation stall
  StallE  in  1  execute holds its register
  FlushE  in  1  kill decode instruction and ValidE
  RegWriteW  in  1  scalar writeback
  RegWriteVW  in  1  vector writeback
  WA3W  in  R  writeback address
  ValidE  out  1  DE register valid
  RA1E, RA2E, WA3E  out  R each  registered RA1, RA2, rd
  RegWriteE, RegWriteVE  out  1 each  registered write enables
  SbErr  out  1  sticky: writeback to a zero counter

Function
REQ-006 The block SHALL decode the fields rd=InstrD[25:21], rs=InstrD[20:16], rt=InstrD[15:11] and V=InstrD[31].
REQ-007 The block SHALL select RA1 as 15 when RegSrcD[1] is 1, else rs.
REQ-008 The block SHALL select RA2 as rd when RegSrcD[0] is 1, else rt.
REQ-009 The block SHALL keep one scalar and one vector counter table, CW bits per entry; pending(x) SHALL be true when cnt(x) is not 0.
REQ-010 Scalar entry 15 ($pc) SHALL never count and SHALL never be pending.
REQ-011 Source checks SHALL use the vector table when V=1 and the scalar table when V=0.
REQ-012 HazardD SHALL equal ValidD AND (pending(RA1) OR pending(RA2) OR any enabled rd-write table with cnt(rd) at 2**CW-1).
REQ-013 ReadyD SHALL equal FlushE OR (NOT StallE AND NOT HazardD); it is combinational.
REQ-014 Issue SHALL occur when ValidD, NOT HazardD, NOT StallE and NOT FlushE are all true.
REQ-015 On issue, the DE register SHALL capture RA1, RA2, rd and the write enables on the next edge, and ValidE SHALL go to 1, giving 1-cycle latency.
REQ-016 When StallE=1 and FlushE=0, the DE register and ValidE SHALL hold.
REQ-017 When FlushE=1, ValidE SHALL go to 0 on the next edge, the decode instruction SHALL be dropped, and no counter SHALL increment; FlushE SHALL have priority over StallE.
REQ-018 When neither issue nor stall occurs, ValidE SHALL go to 0.
REQ-019 On issue, cnt(rd) SHALL increment in each table whose write enable is set; scalar and vector increments SHALL be independent.
REQ-020 RegWriteW SHALL decrement scalar cnt(WA3W), and RegWriteVW SHALL decrement vector cnt(WA3W).
REQ-021 An increment and a decrement of the same entry in the same cycle SHALL leave the count unchanged.
REQ-022 A decrement of a zero counter SHALL leave it at 0 and SHALL set SbErr until reset.
REQ-023 Counters SHALL never wrap; saturation stalls the writer per REQ-012.

Reset
REQ-024 When rst=0 at an edge, every counter, ValidE, RA1E, RA2E, WA3E, RegWriteE, RegWriteVE and SbErr SHALL be 0.
REQ-025 A reset mid-operation SHALL discard all in-flight pending state; writebacks arriving after reset SHALL set SbErr.

Configuration
REQ-026 With macro SB_WB_BYPASS_EN defined, the pending and saturation checks SHALL use the count after the same-cycle writeback decrement, so a source written back this cycle SHALL not stall.
REQ-027 Without SB_WB_BYPASS_EN, the checks SHALL use the registered count, adding one stall cycle.

Verification
REQ-028 The bench SHALL cover: issue with rd=3 scalar, then next instruction rs=3 -> HazardD=1 and ReadyD=0 until RegWriteW with WA3W=3 (bypass on: ready the same cycle; bypass off: ready one cycle later).
REQ-029 The bench SHALL cover: three issues writing rd=7 with CW=2 -> cnt=3, a fourth writer to 7 stalls, and one writeback releases it.
REQ-030 The bench SHALL cover: RegSrcD=2'b10 with rd=15 scalar writes pending -> RA1=15, no hazard, cnt(15) stays 0.
REQ-031 The bench SHALL cover: StallE=1 and FlushE=1 together with a valid instruction -> ValidE=0 next cycle, ReadyD=1, counters unchanged.
REQ-032 The bench SHALL cover: a vector instruction (V=1) with rs=4 while scalar cnt(4)=1 -> no hazard; vector cnt(4)=1 -> hazard.
REQ-033 The bench SHALL cover: rst=0 with counters non-zero, then RegWriteW with WA3W=2 -> all counters 0, SbErr=1.
